btb_update_ctrl: RTL

Sequencing controller for the branch target buffer (BTB) write port. It buffers resolved-branch updates from the execute stage in a small FIFO and converts each one into BTB write controls: `wr_addr`, `tag_in`, `bta_in`, `valid_in`, `predict_in` and the four `ld_*` strobes. After reset, and optionally on a flush, it runs an invalidate sweep across all BTB entries. It sits between the execute/branch-resolution logic and the BTB; the BTB read side (fetch PC lookup) is untouched.

---
 rtl/lc3b_types.sv | 12 +
 rtl/btb_upd_fifo.sv | 45 ++++
 rtl/btb_update_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word/BTB types plus the BTB update-controller struct and state enum
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  btb_index;
  typedef logic [10:0] btb_tag;
  typedef struct packed {
    lc3b_word pc;
    lc3b_word target;
    logic     taken;
  } btb_upd_t;
  typedef enum logic {SWEEP, RUN} btb_ctrl_state;
endpackage

// File: rtl/btb_upd_fifo.sv
// btb_upd_fifo: synchronous FIFO of resolved-branch updates with full/empty flags and sync clear
module btb_upd_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clear,
  input  logic     push,
  input  logic     pop,
  input  btb_upd_t din,
  output btb_upd_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  btb_upd_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr, rd;
  always_comb begin
    full  = cnt_q == CW'(DEPTH);
    empty = cnt_q == '0;
    wr    = push & ~full;
    rd    = pop & ~empty;
    wp_d  = wp_q + AW'(wr);
    rp_d  = rp_q + AW'(rd);
    cnt_d = cnt_q + CW'(wr) - CW'(rd);
    dout  = mem_q[rp_q];
  end
  always_ff @(posedge clk) begin
    if (reset | clear) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      if (wr) mem_q[wp_q] <= din;
    end
  end
endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: queues resolved-branch updates and sequences BTB writes plus the invalidate sweep
// Define BTB_FLUSH_EN to add the flush port (discard queue and re-sweep).
module btb_update_ctrl
  import lc3b_types::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     upd_valid,
  output logic     upd_ready,
  input  lc3b_word upd_pc,
  input  lc3b_word upd_target,
  input  logic     upd_taken,
  input  logic     wr_hold,
`ifdef BTB_FLUSH_EN
  input  logic     flush,
`endif
  output logic     busy,
  output btb_index wr_addr,
  output btb_tag   tag_in,
  output lc3b_word bta_in,
  output logic     valid_in,
  output logic     predict_in,
  output logic     ld_valid,
  output logic     ld_tag,
  output logic     ld_data,
  output logic     ld_predict
);
  btb_ctrl_state state_q, state_d;
  btb_index cnt_q, cnt_d, addr_q;
  btb_tag   tag_q;
  lc3b_word bta_q;
  logic     valid_q, pred_q;
  btb_upd_t head, din;
  logic full, empty, push, pop, sweep, wr_tk, flush_i, unused_pc0;
`ifdef BTB_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif
  assign din        = '{pc: upd_pc, target: upd_target, taken: upd_taken};
  assign unused_pc0 = head.pc[0];
  btb_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush_i),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // Write controls are driven straight from the FIFO head so a pop lands in the BTB at the next edge.
  always_comb begin
    sweep      = state_q == SWEEP;
    busy       = sweep;
    upd_ready  = ~sweep & ~full;
    push       = upd_valid & upd_ready;
    pop        = ~sweep & ~empty & ~wr_hold & ~flush_i & ~reset;
    wr_tk      = pop & head.taken;
    wr_addr    = sweep ? cnt_q : pop ? head.pc[4:1] : addr_q;
    tag_in     = pop ? head.pc[15:5] : tag_q;
    bta_in     = wr_tk ? head.target : bta_q;
    valid_in   = ~sweep & (wr_tk | valid_q);
    predict_in = pop ? head.taken : pred_q;
    ld_valid   = (sweep & ~reset) | wr_tk;
    ld_tag     = wr_tk;
    ld_data    = wr_tk;
    ld_predict = pop;
    state_d    = flush_i ? SWEEP : (sweep && cnt_q == btb_index'(NUM_ENTRIES - 1)) ? RUN : state_q;
    cnt_d      = (sweep & ~flush_i) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
      addr_q  <= '0;
      tag_q   <= '0;
      bta_q   <= '0;
      valid_q <= 1'b0;
      pred_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= wr_addr;
      tag_q   <= tag_in;
      bta_q   <= bta_in;
      valid_q <= valid_in;
      pred_q  <= predict_in;
    end
  end
endmodule
